maxmin_feeder: RTL
==================

# maxmin_feeder

Upstream framing stage for the Maxmin block. Accepts a free-running stream of unsigned numbers over a valid/ready handshake and buffers them in a small FIFO. Releases them to Maxmin as contiguous bursts of exactly BURST_LEN words on `in_num`/`in_valid`. After each burst it waits for Maxmin's `out_valid` before releasing the next one, so Maxmin never sees a partial frame or overlapping frames.

## Interface
- DATA_W, 8, width of every number
- BURST_LEN, 15, words per burst presented to Maxmin
- FIFO_DEPTH, 16, buffer entries; must satisfy BURST_LEN <= FIFO_DEPTH, power of two
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- src_num  input  DATA_W  incoming number
- src_valid  input  1  src_num valid this cycle
- src_ready  output  1  feeder can accept; transfer when src_valid && src_ready
- in_num  output  DATA_W  number to Maxmin; 0 whenever in_valid is low
- in_valid  output  1  burst word valid to Maxmin
- mm_done  input  1  Maxmin out_valid; marks the end of result for the current burst
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently buffered
- frames_sent  output  8  bursts completed (mm_done accepted), wraps 255->0
- proto_err  output  1  sticky; set when mm_done arrives outside WAIT

## Operation
- Reset values: src_ready=1, in_num=0, in_valid=0, fifo_level=0, frames_sent=0, proto_err=0, state=IDLE.
- FIFO push: src_valid && src_ready. src_ready = (fifo_level != FIFO_DEPTH). It is combinational from the registered level only and does not depend on src_valid.
- FIFO pop: one word per cycle while the state is SEND.
- Simultaneous push and pop: level unchanged. A push while full is impossible because ready is low. A pop while empty cannot occur because SEND starts only when level >= BURST_LEN.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level is tracked with one extra bit.
- FSM states:
  - IDLE: if fifo_level >= BURST_LEN, go to SEND and load burst counter = 0.
  - SEND: pop the head into in_num/in_valid registers and increment the burst counter. After the BURST_LEN-th pop, go to WAIT.
  - WAIT: in_valid=0. On mm_done=1, increment frames_sent and go to IDLE.
- mm_done in IDLE or SEND is ignored for state and frames_sent, and sets proto_err.
- Input pushes continue in all states while not full.
- Reset mid-burst: outputs clear immediately (asynchronous), the FIFO is emptied, the partial burst is discarded, and the state returns to IDLE.

## Timing
- in_num and in_valid are registered. A word popped in cycle t appears on in_num in cycle t+1.
- Consider an empty FIFO with back-to-back words accepted in cycles 0..14 (BURST_LEN=15):
  - fifo_level=15 is visible in cycle 15.
  - The FSM enters SEND at the edge ending cycle 15.
  - in_valid is high in cycles 16..30 with words in arrival order.
  - in_valid is low from cycle 31.
- in_valid is never deasserted inside a burst; exactly BURST_LEN consecutive high cycles.
- Minimum gap between bursts is 1 cycle: WAIT plus IDLE, with mm_done accepted in the first WAIT cycle.
- mm_done may arrive in the first cycle after the last in_valid word. It is sampled only in WAIT.
- fifo_level updates one cycle after the push/pop edge. src_ready deasserts in the cycle level reaches FIFO_DEPTH.

## Structure
- Package maxmin_pkg holds:
  - DATA_W and BURST_LEN defaults, shared with Maxmin.
  - The state enum typedef {IDLE, SEND, WAIT}.
  - The num_t typedef logic [DATA_W-1:0].
- Sub-module num_fifo: synchronous FIFO with push/pop/level and async active-high reset. The FSM, burst counter, output registers, frames_sent and proto_err live in maxmin_feeder.

## Test plan
- Single burst: push 1..15 back-to-back from reset -> in_valid high cycles 16..30 carrying 1..15 in order, in_num=0 elsewhere; mm_done in cycle 33 -> frames_sent=1, state IDLE.
- Fill and backpressure: hold mm_done low, push 31 words continuously -> first burst sent; src_ready drops when level hits 16; src_num held until accepted; no word lost or duplicated across both bursts after mm_done.
- Simultaneous push/pop: push one word every cycle during SEND -> fifo_level constant during the burst; order preserved across the FIFO wrap (pointers past index 15).
- Protocol error: pulse mm_done in IDLE and during SEND -> proto_err=1 and stays 1; frames_sent unchanged; burst length still 15.
- Reset mid-burst: assert rst at burst word 7 -> in_valid=0 and fifo_level=0 immediately; after release, a fresh 15-word push produces a complete burst of the new values only.
- Counter wrap: complete 256 bursts -> frames_sent returns to 0.

Source files
------------

// File: rtl/maxmin_pkg.sv
// rtl/maxmin_pkg.sv - shared constants and types for the Maxmin feeder and Maxmin
// Contents: default DATA_W / BURST_LEN / FIFO_DEPTH, FSM state enum, num_t.
package maxmin_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BURST_LEN  = 15;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef logic [DEF_DATA_W-1:0] num_t;

endpackage

// File: rtl/maxmin_feeder_if.sv
// rtl/maxmin_feeder_if.sv - source stream and Maxmin-side signals of the feeder
// master: feeder side (takes src_num/src_valid/mm_done, drives src_ready/in_num/in_valid)
// slave : environment side (mirror of master)
interface maxmin_feeder_if
  import maxmin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] src_num;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] in_num;
  logic              in_valid;
  logic              mm_done;

  modport master (
    input  src_num, src_valid, mm_done,
    output src_ready, in_num, in_valid
  );

  modport slave (
    output src_num, src_valid, mm_done,
    input  src_ready, in_num, in_valid
  );

endinterface

// File: rtl/maxmin_feeder_num_fifo.sv
// rtl/maxmin_feeder_num_fifo.sv - synchronous FIFO buffering numbers for the feeder
// Ports: clk, rst (async active-high), push/push_data, pop/pop_data (head, combinational),
//        level (entries held, one extra bit so DEPTH is representable).
module num_fifo
  import maxmin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage needs no reset: a cleared level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/maxmin_feeder.sv
// rtl/maxmin_feeder.sv - frames a free-running number stream into fixed bursts for Maxmin
// Ports: clk, rst (async active-high); bus (maxmin_feeder_if.master: src stream in,
//        in_num/in_valid burst out, mm_done from Maxmin); fifo_level, frames_sent (wraps),
//        proto_err (sticky, mm_done seen outside WAIT).
module maxmin_feeder
  import maxmin_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  maxmin_feeder_if.master              bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [7:0]                   frames_sent,
  output logic                         proto_err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SEND = SEND;
  localparam logic [1:0] S_WAIT = WAIT;

  logic [1:0]        state;
  logic [CNT_W-1:0]  burst_cnt;
  logic [DATA_W-1:0] in_num_q;
  logic              in_valid_q;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              start;
  logic              last_pop;

  assign bus.src_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push          = bus.src_valid && bus.src_ready;

  // The first word is popped on the IDLE->SEND edge itself so that in_valid
  // rises in the cycle right after the level reaches BURST_LEN.
  assign start    = (state == S_IDLE) && (fifo_level >= LVL_W'(BURST_LEN));
  assign pop      = start || (state == S_SEND);
  assign last_pop = (state == S_SEND) && (burst_cnt == CNT_W'(BURST_LEN - 1));

  num_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.src_num),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level)
  );

  // burst_cnt counts words already popped in the current burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      burst_cnt   <= '0;
      in_num_q    <= '0;
      in_valid_q  <= 1'b0;
      frames_sent <= '0;
      proto_err   <= 1'b0;
    end else begin
      in_valid_q <= pop;
      in_num_q   <= pop ? head : '0;

      if (bus.mm_done && (state != S_WAIT)) begin
        proto_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          burst_cnt <= '0;
          if (start) begin
            burst_cnt <= CNT_W'(1);
            state     <= (BURST_LEN == 1) ? S_WAIT : S_SEND;
          end
        end
        S_SEND: begin
          burst_cnt <= burst_cnt + 1'b1;
          if (last_pop) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mm_done) begin
            frames_sent <= frames_sent + 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_num   = in_num_q;
  assign bus.in_valid = in_valid_q;

endmodule
